i2c_accel_target: RTL and testbench
===================================

// Module: i2c_accel_target
// PURPOSE
//  I2C target (responder) that answers the on-chip opencores I2C master as an
//  emulated ADXL345-style accelerometer, so lab firmware runs against known data.
//  Decodes START/STOP, matches a 7-bit address, keeps an auto-incrementing
//  register pointer, serves a small byte register file and acknowledges writes.
//  Sits on the same open-drain SCL/SDA pair as the master; used in sim and as a loopback target.
// PARAMETERS
//  TARGET_ADDR  7'h53  7-bit I2C address answered
//  DEVICE_ID    8'hE5  read-only value at register 0x00
//  NUM_REGS     64     R/W byte registers at 0x00..NUM_REGS-1; 0x00 and 0x32..0x37 are read-only overlays
// PORTS
//  clk_clk        in   1   system clock; must be >=20x the SCL frequency
//  reset_reset    in   1   synchronous, active-high reset
//  scl_i          in   1   SCL pad input (asynchronous)
//  sda_i          in   1   SDA pad input (asynchronous)
//  sda_oe         out  1   1 = pull SDA low; 0 = release the line
//  axis_x/y/z     in   16  signed samples, 2's complement
//  axis_valid     in   1   1-cycle strobe: capture axis_x/y/z
//  wr_strobe      out  1   1-cycle pulse per accepted write data byte
//  wr_addr        out  8   register address of that byte
//  wr_data        out  8   the byte written
//  busy           out  1   1 from address match until STOP
// BEHAVIOUR
//  - Reset: sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, state IDLE,
//    pointer=0x00, register file and axis snapshot = 0x00.
//  - SCL/SDA pass 2 FF synchroniser stages; edges come from the synchronised
//    values. START = SDA 1->0 while SCL=1. STOP = SDA 0->1 while SCL=1.
//  - Data bits are sampled on the SCL rising edge, MSB first. sda_oe changes
//    only in the cycle after a detected SCL falling edge (max 4 clk after the pad edge).
//  - States: IDLE, DEV_ADDR, ACK_ADDR, REG_PTR, ACK_PTR, WR_DATA, ACK_WR,
//    RD_DATA, RD_ACK, IGNORE.
//    IDLE -START-> DEV_ADDR. After 8 bits:
//      - Address matches: enter ACK_ADDR with sda_oe=1 for the 9th bit and set busy=1.
//        R/W=0 then goes to REG_PTR; R/W=1 goes to RD_DATA.
//      - Address mismatches: no ACK (sda_oe stays 0); go to IGNORE.
//    REG_PTR: 8 bits load the pointer, then ACK_PTR (ACK) -> WR_DATA.
//    WR_DATA: 8 bits -> ACK_WR (ACK).
//      - Issue wr_strobe with wr_addr=pointer and wr_data=byte on the ACK's SCL falling edge.
//      - Store the byte if the address is R/W and <NUM_REGS; otherwise the byte is
//        silently dropped but still ACKed.
//      - pointer++ and return to WR_DATA.
//    RD_DATA: load the byte at the pointer on entry; sda_oe = ~bit for each of the
//      8 bits; release the line; then RD_ACK samples the master's bit.
//      ACK(0) -> pointer++, RD_DATA; NACK(1) -> IGNORE.
//  - Read map:
//      - 0x00 returns DEVICE_ID.
//      - 0x32..0x37 return the X lo,X hi,Y lo,Y hi,Z lo,Z hi snapshot bytes.
//      - Other addresses <NUM_REGS return the stored byte; addresses >=NUM_REGS return 0x00.
//  - Pointer is 8-bit and wraps 0xFF->0x00 in both directions of transfer.
//  - Snapshot: axis_valid loads a staging set. Staging is copied to the
//    visible snapshot on each address-match with R/W=1, so a burst of 6 bytes is coherent.
//    axis_valid in the same cycle as the copy: the new sample is staged, the old one is copied.
//  - STOP in any state: IDLE, sda_oe=0 in the same cycle, busy=0.
//  - START in any state (repeated START): DEV_ADDR, bit counter cleared, sda_oe=0;
//    the pointer is kept.
//  - IGNORE: sda_oe=0 and no decode until START/STOP.
//  - No clock stretching. Reset mid-transfer aborts immediately to the reset state.
// STRUCTURE
//  - Package i2c_target_pkg: state enum; register constants REG_DEVID=8'h00,
//    REG_DATAX0=8'h32..REG_DATAZ1=8'h37.
//  - Sub-module i2c_line_sync: synchronisers + scl_rise/scl_fall/start/stop pulses.
//  - Top: FSM, bit counter(0..8), shift register, pointer, register file, snapshot.
// TESTING
//  1 Write 0x53+W, ptr 0x2D, data 0x08 -> three ACKs; wr_strobe once with
//    wr_addr=0x2D, wr_data=0x08; a read of 0x2D returns 0x08.
//  2 Write ptr 0x00, Sr, 0x53+R, 1 byte NACK -> returns 0xE5; busy drops at STOP.
//  3 Drive axis_x=0x0102, y=0xFFFE, z=0x8000 with axis_valid; burst read of 6 from 0x32
//    -> 02 01 FE FF 00 80; new axis_valid mid-burst does not change those bytes.
//  4 Address 0x1D+W -> no ACK (SDA high on 9th bit); following bytes ignored;
//    no wr_strobe; busy stays 0.
//  5 Write ptr 0xFF, data 0xAA,0xBB -> 2 strobes at addr 0xFF and 0x00; both dropped
//    for storage; pointer ends at 0x01.
//  6 Assert reset_reset mid-RD_DATA while sda_oe=1 -> sda_oe=0 the next cycle;
//    next transaction starts at pointer 0x00.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// Shared state encoding and register map for the emulated ADXL345-style I2C target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_ADDR,
    ST_REG_PTR,
    ST_ACK_PTR,
    ST_WR_DATA,
    ST_ACK_WR,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] REG_DEVID  = 8'h00;
  localparam logic [7:0] REG_DATAX0 = 8'h32;
  localparam logic [7:0] REG_DATAX1 = 8'h33;
  localparam logic [7:0] REG_DATAY0 = 8'h34;
  localparam logic [7:0] REG_DATAY1 = 8'h35;
  localparam logic [7:0] REG_DATAZ0 = 8'h36;
  localparam logic [7:0] REG_DATAZ1 = 8'h37;

  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

  function automatic logic is_snapshot_reg(input logic [7:0] addr);
    return (addr >= REG_DATAX0) && (addr <= REG_DATAZ1);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-stage synchronisers for the SCL/SDA pads plus single-cycle edge and
// START/STOP condition pulses derived from the synchronised levels.
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_prev;
  logic       r_sda_prev;

  // Idle bus level is high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_prev <= r_scl_sync[1];
      r_sda_prev <= r_sda_sync[1];
    end
  end

  assign o_sda      = r_sda_sync[1];
  assign o_scl_rise = r_scl_sync[1] & ~r_scl_prev;
  assign o_scl_fall = ~r_scl_sync[1] & r_scl_prev;
  assign o_start    = r_scl_sync[1] & r_scl_prev & r_sda_prev & ~r_sda_sync[1];
  assign o_stop     = r_scl_sync[1] & r_scl_prev & ~r_sda_prev & r_sda_sync[1];

endmodule

// File: rtl/i2c_accel_target.sv
// I2C target emulating an ADXL345-style accelerometer: address match, auto-
// incrementing register pointer, byte register file and coherent axis snapshot.
module i2c_accel_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h53,
  parameter logic [7:0] DEVICE_ID   = 8'hE5,
  parameter int         NUM_REGS    = 64
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] axis_x,
  input  logic [15:0] axis_y,
  input  logic [15:0] axis_z,
  input  logic        axis_valid,
  output logic        wr_strobe,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_line_sync u_line_sync (
    .i_clk      (clk_clk),
    .i_srst     (reset_reset),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  state_t      r_state, w_state_next;
  logic [3:0]  r_bit_cnt, w_bit_cnt_next;
  logic [7:0]  r_shift, w_shift_next;
  logic [7:0]  r_ptr, w_ptr_next;
  logic        r_rw, w_rw_next;
  logic        r_mack, w_mack_next;
  logic        r_sda_oe, w_sda_oe_next;
  logic        r_busy, w_busy_next;
  logic        w_wr_fire;
  logic        w_snap_copy;
  logic        w_byte_done;
  logic        w_ptr_in_range;
  logic        w_ptr_writable;
  logic [AW-1:0] w_ptr_idx;

  logic        r_wr_strobe;
  logic [7:0]  r_wr_addr, r_wr_data;
  logic [7:0]  r_rd_byte;
  logic [47:0] r_stage, r_snap;
  logic [7:0]  r_regs [NUM_REGS];

  assign w_byte_done    = (r_bit_cnt == BITS_PER_BYTE);
  assign w_ptr_in_range = ({1'b0, r_ptr} < NUM_REGS_W);
  assign w_ptr_writable = w_ptr_in_range && (r_ptr != REG_DEVID) && !is_snapshot_reg(r_ptr);
  assign w_ptr_idx      = r_ptr[AW-1:0];

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_rw      <= 1'b0;
      r_mack    <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_ptr     <= w_ptr_next;
      r_rw      <= w_rw_next;
      r_mack    <= w_mack_next;
      r_sda_oe  <= w_sda_oe_next;
      r_busy    <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_ptr_next     = r_ptr;
    w_rw_next      = r_rw;
    w_mack_next    = r_mack;
    w_sda_oe_next  = r_sda_oe;
    w_busy_next    = r_busy;
    w_wr_fire      = 1'b0;
    w_snap_copy    = 1'b0;
    if (w_stop) begin
      w_state_next  = ST_IDLE;
      w_sda_oe_next = 1'b0;
      w_busy_next   = 1'b0;
    end else if (w_start) begin
      w_state_next   = ST_DEV_ADDR;
      w_bit_cnt_next = '0;
      w_sda_oe_next  = 1'b0;
    end else begin
      case (r_state)
        ST_DEV_ADDR, ST_REG_PTR, ST_WR_DATA: begin
          if (w_scl_rise && !w_byte_done) begin
            w_shift_next   = {r_shift[6:0], w_sda};
            w_bit_cnt_next = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && w_byte_done) begin
            w_bit_cnt_next = '0;
            w_sda_oe_next  = 1'b1;
            if (r_state == ST_REG_PTR) begin
              w_ptr_next   = r_shift;
              w_state_next = ST_ACK_PTR;
            end else if (r_state == ST_WR_DATA) begin
              w_state_next = ST_ACK_WR;
            end else if (r_shift[7:1] == TARGET_ADDR) begin
              w_state_next = ST_ACK_ADDR;
              w_busy_next  = 1'b1;
              w_rw_next    = r_shift[0];
              w_snap_copy  = r_shift[0];
            end else begin
              w_state_next  = ST_IGNORE;
              w_sda_oe_next = 1'b0;
            end
          end
        end
        ST_ACK_ADDR: begin
          if (w_scl_fall) begin
            if (r_rw) begin
              w_state_next  = ST_RD_DATA;
              w_shift_next  = r_rd_byte;
              w_sda_oe_next = ~r_rd_byte[7];
            end else begin
              w_state_next  = ST_REG_PTR;
              w_sda_oe_next = 1'b0;
            end
          end
        end
        ST_ACK_PTR: begin
          if (w_scl_fall) begin
            w_state_next  = ST_WR_DATA;
            w_sda_oe_next = 1'b0;
          end
        end
        ST_ACK_WR: begin
          if (w_scl_fall) begin
            w_state_next  = ST_WR_DATA;
            w_sda_oe_next = 1'b0;
            w_wr_fire     = 1'b1;
            w_ptr_next    = r_ptr + 8'd1;
          end
        end
        ST_RD_DATA: begin
          if (w_scl_rise && !w_byte_done) begin
            w_bit_cnt_next = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && (r_bit_cnt != 4'd0)) begin
            if (w_byte_done) begin
              w_state_next   = ST_RD_ACK;
              w_sda_oe_next  = 1'b0;
              w_bit_cnt_next = '0;
            end else begin
              w_shift_next  = {r_shift[6:0], 1'b0};
              w_sda_oe_next = ~r_shift[6];
            end
          end
        end
        ST_RD_ACK: begin
          // Pointer advances on the ACK rising edge so the next byte is fetched before SCL falls.
          if (w_scl_rise) begin
            w_mack_next = w_sda;
            if (!w_sda) w_ptr_next = r_ptr + 8'd1;
          end else if (w_scl_fall) begin
            if (!r_mack) begin
              w_state_next  = ST_RD_DATA;
              w_shift_next  = r_rd_byte;
              w_sda_oe_next = ~r_rd_byte[7];
            end else begin
              w_state_next = ST_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= w_wr_fire;
      if (w_wr_fire) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= r_shift;
        if (w_ptr_writable) r_regs[w_ptr_idx] <= r_shift;
      end
    end
  end

  // A late axis_valid only touches staging, so an in-flight burst stays coherent.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_stage <= '0;
      r_snap  <= '0;
    end else begin
      if (axis_valid) r_stage <= {axis_z, axis_y, axis_x};
      if (w_snap_copy) r_snap <= r_stage;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_rd_byte <= '0;
    end else begin
      case (r_ptr)
        REG_DEVID:  r_rd_byte <= DEVICE_ID;
        REG_DATAX0: r_rd_byte <= r_snap[7:0];
        REG_DATAX1: r_rd_byte <= r_snap[15:8];
        REG_DATAY0: r_rd_byte <= r_snap[23:16];
        REG_DATAY1: r_rd_byte <= r_snap[31:24];
        REG_DATAZ0: r_rd_byte <= r_snap[39:32];
        REG_DATAZ1: r_rd_byte <= r_snap[47:40];
        default:    r_rd_byte <= w_ptr_in_range ? r_regs[w_ptr_idx] : 8'h00;
      endcase
    end
  end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_i2c_accel_target.sv
// Bus-level bench: a bit-banged I2C master drives the target, and every ACK,
// read byte and write strobe is compared against a byte-array model.
module tb_i2c_accel_target;

  localparam int Q = 5;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        scl_i;
  logic        sda_i;
  logic        sda_oe;
  logic [15:0] axis_x, axis_y, axis_z;
  logic        axis_valid;
  logic        wr_strobe;
  logic [7:0]  wr_addr, wr_data;
  logic        busy;
  logic        sda_m;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  m_regs [64];
  logic [7:0]  m_ptr;
  logic [47:0] m_stage, m_snap;
  logic [15:0] exp_wr [$];
  logic [15:0] obs_wr [$];
  logic [7:0]  wq [$];

  always #5 clk_clk = ~clk_clk;
  assign sda_i = sda_m & ~sda_oe;

  i2c_accel_target dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .sda_oe      (sda_oe),
    .axis_x      (axis_x),
    .axis_y      (axis_y),
    .axis_z      (axis_z),
    .axis_valid  (axis_valid),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  always @(negedge clk_clk) if (wr_strobe) obs_wr.push_back({wr_addr, wr_data});

  initial begin
    repeat (90000) @(posedge clk_clk);
    $display("FAIL watchdog: cycle budget expired before end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_ptr = 8'h00;
    m_stage = '0;
    m_snap = '0;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int k;
    if (a == 8'h00) return 8'hE5;
    if (a >= 8'h32 && a <= 8'h37) begin
      k = int'(a) - 'h32;
      return m_snap[k*8 +: 8];
    end
    if (a < 8'd64) return m_regs[a[5:0]];
    return 8'h00;
  endfunction

  function automatic bit m_writable(input logic [7:0] a);
    return (a != 8'h00) && !(a >= 8'h32 && a <= 8'h37) && (a < 8'd64);
  endfunction

  // ---------------- bus master ----------------
  task automatic wait_q();
    repeat (Q) @(negedge clk_clk);
  endtask

  task automatic bus_start();
    wait_q(); sda_m = 1'b1;
    wait_q(); scl_i = 1'b1;
    wait_q(); sda_m = 1'b0;
    wait_q(); scl_i = 1'b0;
  endtask

  task automatic bus_stop();
    wait_q(); sda_m = 1'b0;
    wait_q(); scl_i = 1'b1;
    wait_q(); sda_m = 1'b1;
    wait_q();
  endtask

  task automatic put_bit(input logic b);
    wait_q(); sda_m = b;
    wait_q(); scl_i = 1'b1;
    wait_q(); wait_q(); scl_i = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    wait_q(); sda_m = 1'b1;
    wait_q(); scl_i = 1'b1;
    wait_q(); b = sda_i;
    wait_q(); scl_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic bit_v;
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(bit_v);
    ack = ~bit_v;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic bit_v;
    b = '0;
    for (int i = 7; i >= 0; i--) begin
      get_bit(bit_v);
      b[i] = bit_v;
    end
    put_bit(nack);
  endtask

  task automatic axis_pulse(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk_clk);
    axis_x = x; axis_y = y; axis_z = z; axis_valid = 1'b1;
    @(negedge clk_clk);
    axis_valid = 1'b0;
    m_stage = {z, y, x};
  endtask

  task automatic check_strobes();
    repeat (4) @(negedge clk_clk);
    check_eq("wr_strobe_count", obs_wr.size(), exp_wr.size());
    while (exp_wr.size() > 0 && obs_wr.size() > 0)
      check_eq("wr_strobe_addr_data", obs_wr.pop_front(), exp_wr.pop_front());
    exp_wr.delete();
    obs_wr.delete();
  endtask

  // ---------------- transactions ----------------
  task automatic do_write(input logic [7:0] p);
    logic ack;
    $display("txn write ptr=%02h bytes=%0d", p, wq.size());
    bus_start();
    send_byte(8'hA6, ack); check_eq("wr_addr_ack", ack, 1);
    check_eq("wr_busy", busy, 1);
    send_byte(p, ack); check_eq("wr_ptr_ack", ack, 1);
    m_ptr = p;
    foreach (wq[i]) begin
      send_byte(wq[i], ack); check_eq("wr_data_ack", ack, 1);
      exp_wr.push_back({m_ptr, wq[i]});
      if (m_writable(m_ptr)) m_regs[m_ptr[5:0]] = wq[i];
      m_ptr++;
    end
    wq.delete();
    bus_stop();
    check_eq("wr_stop_busy", busy, 0);
    check_strobes();
  endtask

  task automatic do_read(input int n, input bit set_ptr, input logic [7:0] p, input int axis_at);
    logic ack;
    logic [7:0] b, exp_b;
    $display("txn read n=%0d set_ptr=%0d ptr=%02h", n, set_ptr, set_ptr ? p : m_ptr);
    if (set_ptr) begin
      bus_start();
      send_byte(8'hA6, ack); check_eq("rdp_addr_ack", ack, 1);
      send_byte(p, ack); check_eq("rdp_ptr_ack", ack, 1);
      m_ptr = p;
    end
    bus_start();
    send_byte(8'hA7, ack); check_eq("rd_addr_ack", ack, 1);
    check_eq("rd_busy", busy, 1);
    m_snap = m_stage;
    for (int i = 0; i < n; i++) begin
      recv_byte(b, (i == n - 1));
      exp_b = m_read(m_ptr);
      check_eq("rd_byte", b, exp_b);
      if (i != n - 1) m_ptr++;
      if (i == axis_at) axis_pulse(16'($urandom), 16'($urandom), 16'($urandom));
    end
    bus_stop();
    check_eq("rd_stop_busy", busy, 0);
    check_strobes();
  endtask

  initial begin
    logic ack;
    reset_reset = 1'b1;
    scl_i = 1'b1; sda_m = 1'b1;
    axis_x = '0; axis_y = '0; axis_z = '0; axis_valid = 1'b0;
    m_reset();
    repeat (4) @(negedge clk_clk);
    check_eq("reset_sda_oe", sda_oe, 0);
    check_eq("reset_wr_strobe", wr_strobe, 0);
    check_eq("reset_wr_addr", wr_addr, 0);
    check_eq("reset_wr_data", wr_data, 0);
    check_eq("reset_busy", busy, 0);
    reset_reset = 1'b0;
    repeat (4) @(negedge clk_clk);

    // 1: single write then readback
    wq.push_back(8'h08);
    do_write(8'h2D);
    do_read(1, 1'b1, 8'h2D, -1);

    // 2: device id via repeated start, NACK on the only byte
    do_read(1, 1'b1, 8'h00, -1);

    // 3: coherent 6-byte snapshot burst with a new sample mid-burst
    axis_pulse(16'h0102, 16'hFFFE, 16'h8000);
    do_read(6, 1'b1, 8'h32, 2);

    // 4: foreign address is never acknowledged
    $display("txn foreign address 0x1D");
    bus_start();
    send_byte(8'h3A, ack); check_eq("foreign_addr_ack", ack, 0);
    check_eq("foreign_busy", busy, 0);
    send_byte(8'h10, ack); check_eq("foreign_byte1_ack", ack, 0);
    send_byte(8'h55, ack); check_eq("foreign_byte2_ack", ack, 0);
    bus_stop();
    check_strobes();

    // 5: pointer wrap on write; both bytes land on non-storable addresses
    wq.push_back(8'h5C);
    do_write(8'h01);
    wq.push_back(8'hAA); wq.push_back(8'hBB);
    do_write(8'hFF);
    do_read(1, 1'b0, 8'h00, -1);

    // 6: reset while the target is pulling SDA low in a read
    $display("txn reset during read");
    bus_start();
    send_byte(8'hA6, ack); check_eq("rst_addr_ack", ack, 1);
    send_byte(8'h2D, ack); check_eq("rst_ptr_ack", ack, 1);
    m_ptr = 8'h2D;
    bus_start();
    send_byte(8'hA7, ack); check_eq("rst_rd_ack", ack, 1);
    repeat (4) @(negedge clk_clk);
    check_eq("rst_pre_sda_oe", sda_oe, 1);
    reset_reset = 1'b1;
    @(negedge clk_clk);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_busy", busy, 0);
    repeat (2) @(negedge clk_clk);
    reset_reset = 1'b0;
    m_reset();
    sda_m = 1'b1;
    wait_q(); scl_i = 1'b1;
    wait_q();
    do_read(2, 1'b0, 8'h00, -1);

    // randomized traffic
    for (int k = 0; k < 30; k++) begin
      int kind, n, sel, at;
      logic [7:0] p;
      kind = int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) axis_pulse(16'($urandom), 16'($urandom), 16'($urandom));
      sel = int'($urandom_range(0, 2));
      p = (sel == 0) ? 8'($urandom_range(0, 63)) :
          (sel == 1) ? 8'($urandom_range(8'h30, 8'h38)) : 8'($urandom);
      case (kind)
        0, 1: begin
          n = int'($urandom_range(1, 3));
          for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
          do_write(p);
        end
        2: begin
          n = int'($urandom_range(1, 4));
          at = int'($urandom_range(0, n)) - 1;
          do_read(n, 1'b1, p, at);
        end
        default: begin
          n = int'($urandom_range(1, 3));
          do_read(n, 1'b0, 8'h00, -1);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
